// File: rtl/otter_iobus_timer_if.sv
// OTTER IOBUS slave-side bus bundle for the timer peripheral.
//   iobus_addr : byte address from the MCU
//   iobus_out  : store data from the MCU
//   iobus_wr   : one-cycle store strobe
//   rd_data    : combinational read data back to the IOBUS_IN mux
//   rd_hit     : address hits a defined register, so the top level selects rd_data
interface otter_iobus_timer_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] rd_data;
  logic        rd_hit;

  modport master (
    output iobus_addr,
    output iobus_out,
    output iobus_wr,
    input  rd_data,
    input  rd_hit
  );

  modport slave (
    input  iobus_addr,
    input  iobus_out,
    input  iobus_wr,
    output rd_data,
    output rd_hit
  );
endinterface

// File: rtl/otter_iobus_timer.sv
// Memory-mapped timer/compare peripheral for the OTTER IOBUS.
// A prescaled counter runs up to a compare value, sets a sticky MATCH flag and,
// when enabled, raises intr for IntrHold cycles. One-shot or auto-reload.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : IOBUS slave (address/store data/strobe in, read data/hit out)
//   intr : interrupt request to the MCU
// Register map (word offsets from BaseAddr, addr[1:0] ignored):
//   0x00 CTRL [0]EN [1]AUTO_RELOAD [2]IRQ_EN
//   0x04 PRESC [15:0], tick every PRESC+1 cycles
//   0x08 CMP, 0x0C COUNT (write loads counter)
//   0x10 STATUS [0]MATCH (write 1 clears), [2:1]state
module otter_iobus_timer #(
  parameter logic [31:0] BaseAddr = 32'h1100_0100,
  parameter int unsigned IntrHold = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  otter_iobus_timer_if.slave        bus,
  output logic                      intr
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      state_q;
  logic [2:0]  ctrl_q;
  logic [15:0] presc_q;
  logic [31:0] cmp_q;
  logic [31:0] count_q;
  logic        match_q;
  logic [15:0] prescaler_q;
  logic [3:0]  hold_q;
  logic        intr_q;

  logic [2:0]  word;
  logic [31:0] wdata;
  logic        hit;
  logic        wr;
  logic        wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
  logic        stop;
  logic        tick;
  logic        match_evt;
  logic        irq_en_d;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign word  = bus.iobus_addr[4:2];
  assign wdata = bus.iobus_out;
  assign hit   = (bus.iobus_addr[31:5] == BaseAddr[31:5]) && (word <= 3'd4);
  assign wr    = bus.iobus_wr && hit;

  assign unused_addr_bits = ^bus.iobus_addr[1:0];

  assign wr_ctrl   = wr && (word == 3'd0);
  assign wr_presc  = wr && (word == 3'd1);
  assign wr_cmp    = wr && (word == 3'd2);
  assign wr_count  = wr && (word == 3'd3);
  assign wr_status = wr && (word == 3'd4);

  // A CTRL write clearing EN aborts the run; it beats a coincident tick so COUNT is retained.
  assign stop      = wr_ctrl && !wdata[0];
  assign tick      = (state_q == StRun) && (prescaler_q == presc_q);
  // A COUNT write on the tick edge wins and suppresses the compare.
  assign match_evt = tick && !stop && !wr_count && (count_q == cmp_q);
  // intr follows the IRQ_EN value that will be in CTRL after this edge.
  assign irq_en_d  = wr_ctrl ? wdata[2] : ctrl_q[2];

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (word)
        3'd0:    rd_data = {29'd0, ctrl_q};
        3'd1:    rd_data = {16'd0, presc_q};
        3'd2:    rd_data = cmp_q;
        3'd3:    rd_data = count_q;
        3'd4:    rd_data = {29'd0, state_q, match_q};
        default: rd_data = '0;
      endcase
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.rd_hit  = hit;
  assign intr        = intr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ctrl_q      <= '0;
      presc_q     <= '0;
      cmp_q       <= '1;
      count_q     <= '0;
      match_q     <= 1'b0;
      prescaler_q <= '0;
      hold_q      <= '0;
      intr_q      <= 1'b0;
    end else begin
      if (wr_ctrl)  ctrl_q  <= wdata[2:0];
      // One-shot completion clears EN, overriding a same-edge CTRL write.
      if (match_evt && !ctrl_q[1]) ctrl_q[0] <= 1'b0;
      if (wr_presc) presc_q <= wdata[15:0];
      if (wr_cmp)   cmp_q   <= wdata;
      if (wr_count) count_q <= wdata;

      // Set beats a same-edge clear.
      if (match_evt)                   match_q <= 1'b1;
      else if (wr_status && wdata[0])  match_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          prescaler_q <= '0;
          if (wr_ctrl && wdata[0]) state_q <= StRun;
        end
        StRun: begin
          if (stop) begin
            state_q     <= StIdle;
            prescaler_q <= '0;
          end else if (wr_count || wr_presc || tick) begin
            prescaler_q <= '0;
          end else begin
            prescaler_q <= prescaler_q + 16'd1;
          end
          if (match_evt) begin
            if (ctrl_q[1]) count_q <= '0;
            else           state_q <= StDone;
          end else if (tick && !stop && !wr_count) begin
            count_q <= count_q + 32'd1;
          end
        end
        StDone: begin
          prescaler_q <= '0;
          if (wr_ctrl) state_q <= wdata[0] ? StRun : StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Hold counter: a new match reloads it; intr stays high until it has drained.
      if (!irq_en_d) begin
        intr_q <= 1'b0;
        hold_q <= '0;
      end else if (match_evt) begin
        intr_q <= 1'b1;
        hold_q <= 4'(IntrHold - 1);
      end else if (hold_q != 4'd0) begin
        hold_q <= hold_q - 4'd1;
      end else begin
        intr_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_otter_iobus_timer.sv
module tb_otter_iobus_timer;
  localparam logic [31:0] B = 32'h1100_0100;

  logic clk;
  logic rst;
  logic intr;
  int   checks;
  int   errors;

  otter_iobus_timer_if bus_if ();

  otter_iobus_timer #(
    .BaseAddr (B),
    .IntrHold (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if),
    .intr (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge; the store lands on the next posedge and returns at the next negedge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_if.iobus_addr = addr;
    bus_if.iobus_out  = data;
    bus_if.iobus_wr   = 1'b1;
    @(negedge clk);
    bus_if.iobus_wr   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d, output logic h);
    bus_if.iobus_addr = addr;
    #1;
    d = bus_if.rd_data;
    h = bus_if.rd_hit;
  endtask

  task automatic chk_reg(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    rd(addr, d, h);
    check(name, d, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        h;
    checks = 0;
    errors = 0;

    vecs[0] = '{B + 32'h04, 32'h1234_ABCD, B + 32'h04, 32'h0000_ABCD, 1'b1};
    vecs[1] = '{B + 32'h08, 32'hCAFE_F00D, B + 32'h0B, 32'hCAFE_F00D, 1'b1};
    vecs[2] = '{B + 32'h0C, 32'hDEAD_BEEF, B + 32'h0C, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{B + 32'h00, 32'hFFFF_FFF6, B + 32'h00, 32'h0000_0006, 1'b1};
    vecs[4] = '{B + 32'h14, 32'h5555_5555, B + 32'h14, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h1100_0208, 32'h0000_0000, B + 32'h08, 32'hCAFE_F00D, 1'b1};
    vecs[6] = '{B + 32'h1C, 32'h0000_0001, B + 32'h10, 32'h0000_0000, 1'b1};
    vecs[7] = '{B + 32'h00, 32'h0000_0000, B + 32'h00, 32'h0000_0000, 1'b1};

    bus_if.iobus_addr = '0;
    bus_if.iobus_out  = '0;
    bus_if.iobus_wr   = 1'b0;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;

    // Reset state
    check("reset_intr", {31'd0, intr}, 32'd0);
    chk_reg("reset_cmp", B + 32'h08, 32'hFFFF_FFFF);
    chk_reg("reset_status", B + 32'h10, 32'h0);
    rd(B + 32'h20, d, h);
    check("reset_unhit_hit", {31'd0, h}, 32'd0);
    check("reset_unhit_data", d, 32'd0);
    @(negedge clk);

    // Register access vectors
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, d, h);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_hit", i), {31'd0, h}, {31'd0, vecs[i].exp_hit});
      @(negedge clk);
    end

    // One-shot: match six edges after EN, intr four cycles
    wr(B + 32'h04, 32'd0);
    wr(B + 32'h08, 32'd5);
    wr(B + 32'h0C, 32'd0);
    wr(B + 32'h00, 32'h5);
    chk_reg("os_status_run", B + 32'h10, 32'h2);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("os_intr_%0d", k), {31'd0, intr}, {31'd0, (k >= 6 && k <= 9)});
      chk_reg($sformatf("os_count_%0d", k), B + 32'h0C, (k <= 5) ? k : 5);
    end
    chk_reg("os_status_done", B + 32'h10, 32'h5);
    chk_reg("os_ctrl_en_cleared", B + 32'h00, 32'h4);
    @(negedge clk);
    wr(B + 32'h10, 32'h1);
    chk_reg("os_status_cleared", B + 32'h10, 32'h4);
    @(negedge clk);
    wr(B + 32'h00, 32'h0);
    chk_reg("os_status_idle", B + 32'h10, 32'h0);
    @(negedge clk);

    // Auto-reload: match every 12 cycles
    wr(B + 32'h04, 32'd2);
    wr(B + 32'h08, 32'd3);
    wr(B + 32'h0C, 32'd0);
    wr(B + 32'h00, 32'h7);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      check($sformatf("ar_intr_%0d", k), {31'd0, intr}, {31'd0, (k >= 12 && (k % 12) < 4)});
      chk_reg($sformatf("ar_count_%0d", k), B + 32'h0C, (k % 12) / 3);
    end
    chk_reg("ar_status", B + 32'h10, 32'h3);
    @(negedge clk);
    wr(B + 32'h00, 32'h0);
    wr(B + 32'h10, 32'h1);

    // Wrap through zero, IRQ disabled
    wr(B + 32'h04, 32'd0);
    wr(B + 32'h08, 32'd1);
    wr(B + 32'h0C, 32'hFFFF_FFFE);
    wr(B + 32'h00, 32'h1);
    chk_reg("wrap_c1", B + 32'h0C, 32'hFFFF_FFFE);
    @(negedge clk);
    chk_reg("wrap_c2", B + 32'h0C, 32'hFFFF_FFFF);
    @(negedge clk);
    chk_reg("wrap_c3", B + 32'h0C, 32'h0);
    @(negedge clk);
    chk_reg("wrap_c4", B + 32'h0C, 32'h1);
    chk_reg("wrap_status_pre", B + 32'h10, 32'h2);
    @(negedge clk);
    chk_reg("wrap_status_match", B + 32'h10, 32'h5);
    chk_reg("wrap_count_hold", B + 32'h0C, 32'h1);
    check("wrap_no_intr", {31'd0, intr}, 32'd0);
    @(negedge clk);
    wr(B + 32'h00, 32'h0);
    wr(B + 32'h10, 32'h1);

    // STATUS clear on the match edge: set wins
    wr(B + 32'h08, 32'd2);
    wr(B + 32'h0C, 32'd0);
    wr(B + 32'h00, 32'h5);
    cycles(2);
    wr(B + 32'h10, 32'h1);
    chk_reg("coll_status", B + 32'h10, 32'h5);
    check("coll_intr", {31'd0, intr}, 32'd1);
    cycles(5);
    wr(B + 32'h00, 32'h0);
    chk_reg("done_to_idle", B + 32'h10, 32'h1);
    @(negedge clk);
    wr(B + 32'h10, 32'h1);

    // COUNT write on a tick edge: write wins
    wr(B + 32'h08, 32'h100);
    wr(B + 32'h0C, 32'd0);
    wr(B + 32'h00, 32'h1);
    cycles(2);
    chk_reg("cw_pre", B + 32'h0C, 32'h2);
    wr(B + 32'h0C, 32'h10);
    chk_reg("cw_load", B + 32'h0C, 32'h10);
    @(negedge clk);
    chk_reg("cw_next", B + 32'h0C, 32'h11);
    @(negedge clk);
    wr(B + 32'h00, 32'h0);

    // Abort at COUNT=7
    wr(B + 32'h08, 32'd100);
    wr(B + 32'h0C, 32'd0);
    wr(B + 32'h00, 32'h5);
    cycles(7);
    chk_reg("ab_pre", B + 32'h0C, 32'h7);
    wr(B + 32'h00, 32'h4);
    chk_reg("ab_status", B + 32'h10, 32'h0);
    cycles(5);
    chk_reg("ab_count_held", B + 32'h0C, 32'h7);
    check("ab_no_intr", {31'd0, intr}, 32'd0);

    // Reset during an intr pulse
    wr(B + 32'h08, 32'd1);
    wr(B + 32'h0C, 32'd0);
    wr(B + 32'h00, 32'h5);
    cycles(2);
    check("rst_intr_pre", {31'd0, intr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_intr_post", {31'd0, intr}, 32'd0);
    chk_reg("rst_status", B + 32'h10, 32'h0);
    chk_reg("rst_cmp", B + 32'h08, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
